// File: rtl/tf520_busarb_if.sv
// tf520_busarb_if
// -----------------------------------------------------------------------------
// Bus-ownership signal bundle for the TF520 bus arbiter. Every signal is
// active low except HIGHZ and DMAOWN.
//
//   master : the arbiter side. It samples the 68000/68EC020 bus inputs and
//            drives BR20, BG, HIGHZ and DMAOWN.
//   slave  : the board/bus side. It drives the request and acknowledge
//            inputs and observes the arbiter outputs.
// -----------------------------------------------------------------------------
interface tf520_busarb_if;
    logic BR;       // 68000-side bus request from a DMA master
    logic BGACK;    // 68000-side bus grant acknowledge
    logic AS;       // card-driven 68000 address strobe (low = bus busy)
    logic BG20;     // 68EC020 bus grant
    logic BR20;     // bus request to the 68EC020
    logic BG;       // bus grant to the DMA master
    logic HIGHZ;    // high = tri-state the card's 68000-bus drivers
    logic DMAOWN;   // high while a DMA master owns the bus

    modport master (
        input  BR, BGACK, AS, BG20,
        output BR20, BG, HIGHZ, DMAOWN
    );

    modport slave (
        output BR, BGACK, AS, BG20,
        input  BR20, BG, HIGHZ, DMAOWN
    );
endinterface

// File: rtl/tf520_busarb.sv
// tf520_busarb
// -----------------------------------------------------------------------------
// Bus-ownership arbiter for the TF520 card, clocked from CLK7M.
//
// Runs the 68000 BR/BG/BGACK protocol toward Amiga DMA masters and the
// BR20/BG20 protocol toward the 68EC020. When a DMA master requests the bus
// the card first asks the 020 to stop, waits for the 68000 bus to be idle for
// IDLE_CYCLES edges, then issues BG. While the master owns the bus HIGHZ
// tri-states the card's AS/UDS/LDS/RW00/VMA drivers; HIGHZ is held for one
// extra RELEASE cycle so the master's drivers are off before ours return.
//
// All outputs are registered and decoded from the next state, so there is no
// combinational path from any input to any output.
//
// Optional feature (compile-time macro TF520_GRANT_TIMEOUT_EN):
//   when defined, a grant that is not acknowledged within TIMEOUT_CYCLES
//   GRANT-state cycles is withdrawn and the arbiter returns to IDLE.
//   When undefined, GRANT persists until BGACK asserts or BR withdraws.
// -----------------------------------------------------------------------------
module tf520_busarb #(
    parameter int IDLE_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic           CLK7M,
    input  logic           RESET,
    tf520_busarb_if.master bus
);

    // -------------------------------------------------------------------------
    // Counter sizing: wide enough for the larger limit, saturating.
    // -------------------------------------------------------------------------
    localparam int CNT_MAX = (IDLE_CYCLES > TIMEOUT_CYCLES) ? IDLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_QUAL    = 3'd2,
        ST_GRANT   = 3'd3,
        ST_OWNED   = 3'd4,
        ST_RELEASE = 3'd5
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Synchronisers for the asynchronous inputs. AS is already CLK7M-aligned
    // and is used directly.
    // -------------------------------------------------------------------------
    logic br_s1_q,    br_s2_q;
    logic bgack_s1_q, bgack_s2_q;
    logic bg20_s1_q,  bg20_s2_q;

    // Two-flop synchronisers; both stages idle high (inactive) out of reset.
    always_ff @(posedge CLK7M or negedge RESET) begin
        if (!RESET) begin
            br_s1_q    <= 1'b1;
            br_s2_q    <= 1'b1;
            bgack_s1_q <= 1'b1;
            bgack_s2_q <= 1'b1;
            bg20_s1_q  <= 1'b1;
            bg20_s2_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old
            // value of the previous one; blocking here would collapse the chain.
            br_s1_q    <= bus.BR;
            br_s2_q    <= br_s1_q;
            bgack_s1_q <= bus.BGACK;
            bgack_s2_q <= bgack_s1_q;
            bg20_s1_q  <= bus.BG20;
            bg20_s2_q  <= bg20_s1_q;
        end
    end

    logic br_s, bgack_s, bg20_s;
    assign br_s    = br_s2_q;
    assign bgack_s = bgack_s2_q;
    assign bg20_s  = bg20_s2_q;

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             br20_q,     br20_d;
    logic             bg_q,       bg_d;
    logic             highz_q,    highz_d;
    logic             dmaown_q,   dmaown_d;

`ifdef TF520_GRANT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tout_cnt_q, tout_cnt_d;
`endif

    // Next-state logic, bus-idle and grant-timeout counters, output decode.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        idle_cnt_d = '0;
`ifdef TF520_GRANT_TIMEOUT_EN
        tout_cnt_d = '0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (!br_s && bgack_s) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                // A withdrawn request abandons the cycle before the 020 grant
                // is acted on. The idle counter is cleared by its default.
                if (br_s) begin
                    state_d = ST_IDLE;
                end else if (!bg20_s) begin
                    state_d = ST_QUAL;
                end
            end

            ST_QUAL: begin
                // Count consecutive edges with the 68000 bus idle; any busy
                // edge restarts the qualification.
                if (bus.AS && bgack_s) begin
                    idle_cnt_d = sat_inc(idle_cnt_q);
                end

                if (br_s) begin
                    state_d = ST_IDLE;
                end else if (idle_cnt_d >= IDLE_LIMIT) begin
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
`ifdef TF520_GRANT_TIMEOUT_EN
                tout_cnt_d = sat_inc(tout_cnt_q);
`endif
                // Acknowledge wins over withdrawal and timeout on the same edge.
                if (!bgack_s) begin
                    state_d = ST_OWNED;
                end else if (br_s) begin
                    state_d = ST_IDLE;
`ifdef TF520_GRANT_TIMEOUT_EN
                end else if (tout_cnt_d >= TOUT_LIMIT) begin
                    state_d = ST_IDLE;
`endif
                end
            end

            ST_OWNED: begin
                // BR re-assertion is ignored here; only BGACK ends ownership.
                if (bgack_s) begin
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // One turnaround cycle with the card's drivers still off.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are a pure function of the next state, registered below.
        br20_d   = 1'b0;
        bg_d     = 1'b1;
        highz_d  = 1'b0;
        dmaown_d = 1'b0;
        unique case (state_d)
            ST_IDLE: begin
                br20_d = 1'b1;
            end
            ST_REQ, ST_QUAL: begin
                br20_d = 1'b0;
            end
            ST_GRANT: begin
                bg_d = 1'b0;
            end
            ST_OWNED: begin
                highz_d  = 1'b1;
                dmaown_d = 1'b1;
            end
            ST_RELEASE: begin
                highz_d = 1'b1;
            end
            default: begin
                br20_d = 1'b1;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge CLK7M or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            idle_cnt_q <= '0;
            br20_q     <= 1'b1;
            bg_q       <= 1'b1;
            highz_q    <= 1'b0;
            dmaown_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            br20_q     <= br20_d;
            bg_q       <= bg_d;
            highz_q    <= highz_d;
            dmaown_q   <= dmaown_d;
        end
    end

`ifdef TF520_GRANT_TIMEOUT_EN
    // Grant-timeout counter register.
    always_ff @(posedge CLK7M or negedge RESET) begin
        if (!RESET) begin
            tout_cnt_q <= '0;
        end else begin
            tout_cnt_q <= tout_cnt_d;
        end
    end
`endif

    assign bus.BR20   = br20_q;
    assign bus.BG     = bg_q;
    assign bus.HIGHZ  = highz_q;
    assign bus.DMAOWN = dmaown_q;

endmodule

// File: tb/tb_tf520_busarb.sv
// tb_tf520_busarb
// -----------------------------------------------------------------------------
// Directed bench for tf520_busarb. Expected output vectors
// {BR20, BG, HIGHZ, DMAOWN} are pushed to a scoreboard, tagged with the
// CLK7M edge at which they must appear, when each stimulus step is driven;
// they are popped and compared half a cycle after that edge.
// Honours TF520_GRANT_TIMEOUT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_tf520_busarb;

    localparam logic [3:0] IDLE_O  = 4'b1100;  // BR20=1 BG=1 HIGHZ=0 DMAOWN=0
    localparam logic [3:0] REQ_O   = 4'b0100;  // request/qualify: BR20 low
    localparam logic [3:0] GRANT_O = 4'b0000;  // BG low
    localparam logic [3:0] OWN_O   = 4'b0111;  // HIGHZ and DMAOWN high
    localparam logic [3:0] REL_O   = 4'b0110;  // HIGHZ held, DMAOWN dropped

    logic CLK7M = 1'b0;
    logic RESET;

    tf520_busarb_if bus ();

    tf520_busarb #(
        .IDLE_CYCLES    (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK7M (CLK7M),
        .RESET (RESET),
        .bus   (bus.master)
    );

    always #5 CLK7M = ~CLK7M;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] want;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    function automatic logic [3:0] outs();
        return {bus.BR20, bus.BG, bus.HIGHZ, bus.DMAOWN};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, want, cyc);
        end
    endtask

    // Expect vector e on the edge dc cycles from now.
    task automatic exp_at(input int dc, input string tag, input logic [3:0] e);
        exp_t item;
        item.cyc  = cyc + dc;
        item.tag  = tag;
        item.want = e;
        sb.push_back(item);
    endtask

    task automatic exp_span(input int from, input int to, input string tag, input logic [3:0] e);
        for (int i = from; i <= to; i++) exp_at(i, tag, e);
    endtask

    // Advance n edges; after each, compare every scoreboard entry due on it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK7M);
            cyc++;
            @(negedge CLK7M);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    check(sb[i].tag, outs(), sb[i].want);
                    sb.delete(i);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.BR    = 1'b1;
        bus.BGACK = 1'b1;
        bus.AS    = 1'b1;
        bus.BG20  = 1'b1;
        RESET     = 1'b0;
        repeat (2) @(negedge CLK7M);
        check("reset_state", outs(), IDLE_O);
        RESET = 1'b1;
        exp_span(1, 2, "idle_quiet", IDLE_O);
        tick(2);

        // ---- Normal DMA cycle --------------------------------------------
        bus.BR = 1'b0;
        exp_span(1, 2, "dma_br_sync", IDLE_O);
        exp_at(3, "dma_br20_low", REQ_O);
        tick(3);
        exp_span(1, 2, "dma_req_hold", REQ_O);
        tick(2);
        bus.BG20 = 1'b0;
        exp_span(1, 4, "dma_qual", REQ_O);
        exp_at(5, "dma_bg_low", GRANT_O);
        tick(5);
        exp_span(1, 3, "dma_grant_hold", GRANT_O);
        tick(3);
        bus.BGACK = 1'b0;
        bus.BR    = 1'b1;
        exp_span(1, 2, "dma_bgack_sync", GRANT_O);
        exp_span(3, 9, "dma_owned", OWN_O);
        tick(9);
        bus.BR = 1'b0;                          // re-request while owned
        exp_span(1, 11, "dma_owned_br_ignored", OWN_O);
        tick(11);
        bus.BGACK = 1'b1;                       // 20 cycles after BGACK fell
        exp_span(1, 2, "rel_bgack_sync", OWN_O);
        exp_at(3, "rel_release", REL_O);
        exp_at(4, "rel_idle", IDLE_O);
        exp_span(5, 7, "b2b_req_qual", REQ_O);
        exp_at(8, "b2b_grant", GRANT_O);
        tick(8);

        // ---- Withdrawal in GRANT -----------------------------------------
        bus.BR = 1'b1;
        exp_span(1, 2, "wd_sync", GRANT_O);
        exp_span(3, 6, "wd_idle", IDLE_O);
        tick(6);
        bus.BG20 = 1'b1;
        exp_span(1, 3, "wd_bg20_off", IDLE_O);
        tick(3);

        // ---- Busy bus: AS low holds off the grant --------------------------
        bus.BR = 1'b0;
        bus.AS = 1'b0;
        exp_span(1, 2, "busy_sync", IDLE_O);
        exp_span(3, 5, "busy_req", REQ_O);
        tick(5);
        bus.BG20 = 1'b0;
        exp_span(1, 13, "busy_hold", REQ_O);
        tick(13);
        bus.AS = 1'b1;
        exp_at(1, "busy_as_edge1", REQ_O);
        exp_at(2, "busy_bg_low", GRANT_O);
        tick(2);

        // ---- Unacknowledged grant ----------------------------------------
`ifdef TF520_GRANT_TIMEOUT_EN
        exp_span(1, 15, "to_grant", GRANT_O);
        exp_at(16, "to_expire", IDLE_O);
        tick(16);
        bus.BR = 1'b1;
        exp_span(1, 2, "to_rereq", REQ_O);
        exp_span(3, 5, "to_idle", IDLE_O);
        tick(5);
`else
        exp_span(1, 110, "nto_grant", GRANT_O);
        tick(110);
        bus.BR = 1'b1;
        exp_span(1, 2, "nto_wd_sync", GRANT_O);
        exp_span(3, 5, "nto_idle", IDLE_O);
        tick(5);
`endif

        // ---- Short BR glitch between edges -------------------------------
        bus.BG20 = 1'b1;
        exp_span(1, 3, "glitch_pre", IDLE_O);
        tick(3);
        #1 bus.BR = 1'b0;
        #2 bus.BR = 1'b1;
        exp_span(1, 6, "glitch_ignored", IDLE_O);
        tick(6);

        // ---- Asynchronous reset while the DMA master owns the bus --------
        bus.BG20 = 1'b0;
        exp_span(1, 3, "own2_pre", IDLE_O);
        tick(3);
        bus.BR = 1'b0;
        exp_span(1, 2, "own2_sync", IDLE_O);
        exp_span(3, 5, "own2_req", REQ_O);
        exp_at(6, "own2_grant", GRANT_O);
        tick(6);
        bus.BGACK = 1'b0;
        exp_span(1, 2, "own2_bgack_sync", GRANT_O);
        exp_at(3, "own2_owned", OWN_O);
        tick(3);
        #2;
        RESET     = 1'b0;
        bus.BR    = 1'b1;
        bus.BGACK = 1'b1;
        #1 check("async_reset", outs(), IDLE_O);
        @(negedge CLK7M);
        RESET = 1'b1;
        exp_span(1, 4, "post_reset_idle", IDLE_O);
        tick(4);

        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drained: observed %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
